// File: rtl/iob_uart_host_pkg.sv
// Shared types and IOb lane helpers for the iob_uart host initiator.
package iob_uart_host_pkg;

  typedef enum logic [3:0] {
    StInitSrst1,
    StInitSrst0,
    StInitDiv,
    StInitTxen,
    StInitRxen,
    StIdle,
    StTxPoll,
    StTxWrite,
    StRxPoll,
    StRxRead
  } state_e;

  localparam logic SzByte = 1'b0;  // 1-byte write
  localparam logic SzHalf = 1'b1;  // 2-byte write

  function automatic logic [3:0] strb_f(input logic [1:0] lane, input logic half);
    logic [3:0] base;
    base = half ? 4'b0011 : 4'b0001;
    return base << lane;
  endfunction

  function automatic logic [31:0] wdata_f(input logic [15:0] data, input logic [1:0] lane);
    logic [31:0] word;
    word = {16'h0000, data};
    return word << {lane, 3'b000};
  endfunction

  function automatic logic [7:0] lane_f(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/iob_uart_host_req.sv
// Single-outstanding IOb request engine: launches one access, reports completion and read byte.
module iob_uart_host_req
  import iob_uart_host_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_n_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [15:0]         data_i,
  input  logic                half_i,
  input  logic                is_read_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [7:0]          rbyte_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_rvalid_i,
  input  logic                iob_ready_i
);

  logic                r_avalid, r_pending, r_is_read;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                w_accept;

  assign w_accept = r_avalid & iob_ready_i;
  assign busy_o   = r_avalid | r_pending;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_avalid  <= 1'b0;
      r_pending <= 1'b0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (cke_i) begin
      if (start_i && !busy_o) begin
        r_avalid  <= 1'b1;
        r_is_read <= is_read_i;
        r_addr    <= addr_i;
        r_wdata   <= is_read_i ? '0 : wdata_f(data_i, addr_i[1:0]);
        r_wstrb   <= is_read_i ? '0 : strb_f(addr_i[1:0], half_i);
      end else if (w_accept) begin
        r_avalid  <= 1'b0;
        r_pending <= r_is_read;
      end else if (r_pending && iob_rvalid_i) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Writes finish on accept; reads finish on the first rvalid after accept.
  assign done_o  = cke_i & ((w_accept & ~r_is_read) | (r_pending & iob_rvalid_i));
  assign rbyte_o = lane_f(iob_rdata_i, r_addr[1:0]);

  assign iob_avalid_o = r_avalid;
  assign iob_addr_o   = r_addr;
  assign iob_wdata_o  = r_wdata;
  assign iob_wstrb_o  = r_wstrb;

endmodule

// File: rtl/iob_uart_host.sv
// IOb initiator that initialises an iob_uart and shuttles bytes between streams and its CSRs.
module iob_uart_host
  import iob_uart_host_pkg::*;
#(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DATA_W      = 32,
  parameter logic [15:0] DIV         = 16'd100,
  parameter int unsigned POLL_GAP    = 8,
  parameter int unsigned A_SOFTRESET = 0,
  parameter int unsigned A_DIV       = 2,
  parameter int unsigned A_TXDATA    = 4,
  parameter int unsigned A_TXEN      = 5,
  parameter int unsigned A_RXEN      = 6,
  parameter int unsigned A_TXREADY   = 0,
  parameter int unsigned A_RXREADY   = 1,
  parameter int unsigned A_RXDATA    = 4
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_n_i,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_rvalid_i,
  input  logic                iob_ready_i,
  input  logic [7:0]          tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic [7:0]          rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                init_done_o
);

  localparam int unsigned GapW = $clog2(POLL_GAP + 2);

  state_e            r_state, w_state_next;
  logic              r_rr_tx, r_rx_full, r_init_done;
  logic [GapW-1:0]   r_gap_tx, r_gap_rx;
  logic [7:0]        r_tx_byte, r_rx_data;

  logic              w_start, w_busy, w_done, w_is_read, w_half;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       w_data;
  logic [7:0]        w_rbyte;
  logic              w_tx_elig, w_rx_elig, w_grant_tx, w_grant_rx;

  assign w_tx_elig  = tx_valid_i && (r_gap_tx == '0);
  assign w_rx_elig  = !r_rx_full && (r_gap_rx == '0);
  assign w_grant_tx = (r_state == StIdle) && w_tx_elig && (!w_rx_elig || r_rr_tx);
  assign w_grant_rx = (r_state == StIdle) && w_rx_elig && !w_grant_tx;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= StInitSrst1;
    end else if (cke_i) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StInitSrst1: if (w_done) w_state_next = StInitSrst0;
      StInitSrst0: if (w_done) w_state_next = StInitDiv;
      StInitDiv:   if (w_done) w_state_next = StInitTxen;
      StInitTxen:  if (w_done) w_state_next = StInitRxen;
      StInitRxen:  if (w_done) w_state_next = StIdle;
      StIdle: begin
        if (w_grant_tx)      w_state_next = StTxPoll;
        else if (w_grant_rx) w_state_next = StRxPoll;
      end
      StTxPoll:  if (w_done) w_state_next = w_rbyte[0] ? StTxWrite : StIdle;
      StTxWrite: if (w_done) w_state_next = StIdle;
      StRxPoll:  if (w_done) w_state_next = w_rbyte[0] ? StRxRead : StIdle;
      StRxRead:  if (w_done) w_state_next = StIdle;
      default:   w_state_next = StInitSrst1;
    endcase
  end

  always_comb begin
    w_addr    = '0;
    w_data    = '0;
    w_half    = SzByte;
    w_is_read = 1'b0;
    unique case (r_state)
      StInitSrst1: begin w_addr = ADDR_W'(A_SOFTRESET); w_data = 16'd1; end
      StInitSrst0: begin w_addr = ADDR_W'(A_SOFTRESET); w_data = 16'd0; end
      StInitDiv:   begin w_addr = ADDR_W'(A_DIV); w_data = DIV; w_half = SzHalf; end
      StInitTxen:  begin w_addr = ADDR_W'(A_TXEN); w_data = 16'd1; end
      StInitRxen:  begin w_addr = ADDR_W'(A_RXEN); w_data = 16'd1; end
      StTxPoll:    begin w_addr = ADDR_W'(A_TXREADY); w_is_read = 1'b1; end
      StTxWrite:   begin w_addr = ADDR_W'(A_TXDATA); w_data = {8'h00, r_tx_byte}; end
      StRxPoll:    begin w_addr = ADDR_W'(A_RXREADY); w_is_read = 1'b1; end
      StRxRead:    begin w_addr = ADDR_W'(A_RXDATA); w_is_read = 1'b1; end
      default:     ;
    endcase
    w_start    = (r_state != StIdle) && !w_busy;
    tx_ready_o = (r_state == StTxWrite) && w_done;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_rr_tx     <= 1'b1;
      r_gap_tx    <= '0;
      r_gap_rx    <= '0;
      r_tx_byte   <= '0;
      r_rx_data   <= '0;
      r_rx_full   <= 1'b0;
      r_init_done <= 1'b0;
    end else if (cke_i) begin
      // Pointer moves to the service that was not just granted.
      if (w_grant_tx) begin
        r_rr_tx   <= 1'b0;
        r_tx_byte <= tx_data_i;
      end else if (w_grant_rx) begin
        r_rr_tx <= 1'b1;
      end
      if (r_state == StTxPoll && w_done && !w_rbyte[0]) r_gap_tx <= GapW'(POLL_GAP);
      else if (r_gap_tx != '0)                          r_gap_tx <= r_gap_tx - GapW'(1);
      if (r_state == StRxPoll && w_done && !w_rbyte[0]) r_gap_rx <= GapW'(POLL_GAP);
      else if (r_gap_rx != '0)                          r_gap_rx <= r_gap_rx - GapW'(1);
      if (r_state == StRxRead && w_done) begin
        r_rx_data <= w_rbyte;
        r_rx_full <= 1'b1;
      end else if (r_rx_full && rx_ready_i) begin
        r_rx_full <= 1'b0;
      end
      if (r_state == StInitRxen && w_done) r_init_done <= 1'b1;
    end
  end

  assign rx_data_o   = r_rx_data;
  assign rx_valid_o  = r_rx_full;
  assign init_done_o = r_init_done;

  iob_uart_host_req #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req (
    .clk_i       (clk_i),
    .cke_i       (cke_i),
    .arst_n_i    (arst_n_i),
    .start_i     (w_start),
    .addr_i      (w_addr),
    .data_i      (w_data),
    .half_i      (w_half),
    .is_read_i   (w_is_read),
    .busy_o      (w_busy),
    .done_o      (w_done),
    .rbyte_o     (w_rbyte),
    .iob_avalid_o(iob_avalid_o),
    .iob_addr_o  (iob_addr_o),
    .iob_wdata_o (iob_wdata_o),
    .iob_wstrb_o (iob_wstrb_o),
    .iob_rdata_i (iob_rdata_i),
    .iob_rvalid_i(iob_rvalid_i),
    .iob_ready_i (iob_ready_i)
  );

endmodule

// File: tb/tb_iob_uart_host.sv
// Directed bench for iob_uart_host with a small behavioural UART CSR responder.
module tb_iob_uart_host;

  logic        clk = 1'b0;
  logic        cke = 1'b1;
  logic        arst_n = 1'b0;
  logic        avalid;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        init_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Responder state
  int          txr_zeros = 0;
  bit          rxr_val = 1'b0;
  logic [7:0]  rxq[$];
  int          stall_left = 0;
  int          rxdata_lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;
  int          tx_pulses = 0;
  logic [2:0]  l_addr[$];
  logic [3:0]  l_strb[$];
  logic [31:0] l_data[$];
  int          l_cyc[$];

  iob_uart_host #(
    .ADDR_W(3),
    .DATA_W(32),
    .DIV(16'd100),
    .POLL_GAP(8)
  ) dut (
    .clk_i       (clk),
    .cke_i       (cke),
    .arst_n_i    (arst_n),
    .iob_avalid_o(avalid),
    .iob_addr_o  (addr),
    .iob_wdata_o (wdata),
    .iob_wstrb_o (wstrb),
    .iob_rdata_i (rdata),
    .iob_rvalid_i(rvalid),
    .iob_ready_i (ready),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .init_done_o (init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART CSR responder: decides ready at negedge, logs accepts, returns read data later.
  initial begin
    logic [7:0]  v;
    logic [31:0] rd;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        pend_cnt = 0;
        rvalid   = 1'b0;
        ready    = 1'b1;
      end else begin
        rvalid = 1'b0;
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            rvalid = 1'b1;
            rdata  = pend_data;
          end
        end
        ready = !(stall_left > 0 && avalid && addr == 3'd2 && wstrb != 4'd0);
        if (!ready) stall_left--;
        #1;
        if (avalid && ready) begin
          l_addr.push_back(addr);
          l_strb.push_back(wstrb);
          l_data.push_back(wdata);
          l_cyc.push_back(cyc);
          if (wstrb == 4'd0) begin
            case (addr)
              3'd0: begin
                v = (txr_zeros > 0) ? 8'h00 : 8'h01;
                if (txr_zeros > 0) txr_zeros--;
              end
              3'd1:    v = rxr_val ? 8'h01 : 8'h00;
              3'd4:    v = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
              default: v = 8'h00;
            endcase
            rd = 32'hFEFE_FEFE;
            rd[8*addr[1:0] +: 8] = v;
            pend_data = rd;
            pend_cnt  = (addr == 3'd4) ? rxdata_lat : 1;
          end
        end
        if (tx_ready) tx_pulses++;
      end
    end
  end

  task automatic clear_log();
    l_addr.delete();
    l_strb.delete();
    l_data.delete();
    l_cyc.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    clear_log();
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    n_tests++; if (avalid !== 1'b0) begin n_fail++; $display("FAIL reset_avalid: got %b expected 0", avalid); end
    n_tests++; if (addr !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr); end
    n_tests++; if (wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", wdata); end
    n_tests++; if (wstrb !== 4'd0) begin n_fail++; $display("FAIL reset_wstrb: got %h expected 0", wstrb); end
    n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_tests++; if (rx_data !== 8'd0) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 0", rx_data); end
    n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
  endtask

  task automatic test_init(input string tag);
    logic [2:0]  e_addr[5];
    logic [3:0]  e_strb[5];
    logic [31:0] e_data[5];
    int k;
    e_addr = '{3'd0, 3'd0, 3'd2, 3'd5, 3'd6};
    e_strb = '{4'b0001, 4'b0001, 4'b1100, 4'b0010, 4'b0100};
    e_data = '{32'h1, 32'h0, 32'h0064_0000, 32'h0000_0100, 32'h0001_0000};
    k = 0;
    while (init_done !== 1'b1 && k < 200) begin
      @(negedge clk); #2; k++;
    end
    n_tests++;
    if (init_done !== 1'b1) begin
      n_fail++; $display("FAIL %s_done: got %b expected 1", tag, init_done);
    end
    n_tests++;
    if (l_addr.size() < 5) begin
      n_fail++; $display("FAIL %s_count: got %0d expected >=5", tag, l_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (l_addr[i] !== e_addr[i] || l_strb[i] !== e_strb[i] || l_data[i] !== e_data[i]) begin
          n_fail++;
          $display("FAIL %s_wr%0d: got a=%0d s=%b d=%h expected a=%0d s=%b d=%h", tag, i,
                   l_addr[i], l_strb[i], l_data[i], e_addr[i], e_strb[i], e_data[i]);
        end
      end
    end
  endtask

  task automatic test_tx();
    int k, n_poll, n_wr, last;
    clear_log();
    tx_pulses = 0;
    txr_zeros = 2;
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk); #2; k++;
    end while (tx_ready !== 1'b1 && k < 500);
    n_tests++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_timeout: got 0 expected tx_ready 1"); end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (30) @(negedge clk);
    n_poll = 0; n_wr = 0; last = -100;
    for (int i = 0; i < l_addr.size(); i++) begin
      if (l_addr[i] == 3'd0 && l_strb[i] == 4'd0) begin
        n_poll++;
        if (n_poll > 1) begin
          n_tests++;
          if (l_cyc[i] - last < 9) begin
            n_fail++; $display("FAIL tx_poll_gap: got %0d expected >=9", l_cyc[i] - last);
          end
        end
        last = l_cyc[i];
      end
      if (l_addr[i] == 3'd4 && l_strb[i] != 4'd0) begin
        n_wr++;
        n_tests++;
        if (l_strb[i] !== 4'b0001 || l_data[i] !== 32'h0000_00A5) begin
          n_fail++; $display("FAIL tx_write: got s=%b d=%h expected s=0001 d=000000a5", l_strb[i], l_data[i]);
        end
      end
    end
    n_tests++; if (n_poll != 3) begin n_fail++; $display("FAIL tx_polls: got %0d expected 3", n_poll); end
    n_tests++; if (n_wr != 1) begin n_fail++; $display("FAIL tx_writes: got %0d expected 1", n_wr); end
    n_tests++; if (tx_pulses != 1) begin n_fail++; $display("FAIL tx_pulse: got %0d expected 1", tx_pulses); end
  endtask

  task automatic test_rx_backpressure();
    int k, n_rd, idx, n_after;
    clear_log();
    rx_ready = 1'b0;
    rxq.push_back(8'h31);
    rxq.push_back(8'h32);
    rxr_val = 1'b1;
    k = 0;
    do begin
      @(negedge clk); #2; k++;
    end while (rx_valid !== 1'b1 && k < 200);
    n_tests++; if (rx_data !== 8'h31) begin n_fail++; $display("FAIL rx_first: got %h expected 31", rx_data); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h31) begin
        n_fail++; $display("FAIL rx_hold%0d: got v=%b d=%h expected v=1 d=31", i, rx_valid, rx_data);
      end
    end
    n_rd = 0; idx = -1; n_after = 0;
    for (int i = 0; i < l_addr.size(); i++) begin
      if (l_addr[i] == 3'd4 && l_strb[i] == 4'd0) begin n_rd++; idx = i; end
      else if (l_addr[i] == 3'd1 && idx >= 0) n_after++;
    end
    n_tests++; if (n_rd != 1) begin n_fail++; $display("FAIL rx_reads: got %0d expected 1", n_rd); end
    n_tests++; if (n_after != 0) begin n_fail++; $display("FAIL rx_extra_polls: got %0d expected 0", n_after); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    k = 0;
    do begin
      @(negedge clk); #2; k++;
    end while (rx_valid !== 1'b1 && k < 200);
    rxr_val = 1'b0;
    n_tests++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h32) begin
      n_fail++; $display("FAIL rx_second: got v=%b d=%h expected v=1 d=32", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [2:0] polls[$];
    logic [2:0] exp_p[4];
    int k, n_wr;
    exp_p = '{3'd0, 3'd1, 3'd0, 3'd1};
    arst_n = 1'b0;
    tx_data = 8'h5A; tx_valid = 1'b1; txr_zeros = 0;
    rxr_val = 1'b1; rxq.delete(); rxq.push_back(8'h41); rxq.push_back(8'h42);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    release_reset();
    k = 0;
    do begin
      @(negedge clk); #2; k++;
      polls.delete();
      for (int i = 0; i < l_addr.size(); i++)
        if (l_strb[i] == 4'd0 && (l_addr[i] == 3'd0 || l_addr[i] == 3'd1)) polls.push_back(l_addr[i]);
    end while (polls.size() < 4 && k < 500);
    tx_valid = 1'b0;
    rxr_val  = 1'b0;
    n_tests++;
    if (polls.size() < 4) begin
      n_fail++; $display("FAIL arb_timeout: got %0d polls expected 4", polls.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (polls[i] !== exp_p[i]) begin
          n_fail++; $display("FAIL arb_order%0d: got addr %0d expected %0d", i, polls[i], exp_p[i]);
        end
      end
    end
    repeat (20) @(negedge clk);
    n_wr = 0;
    for (int i = 0; i < l_addr.size(); i++)
      if (l_addr[i] == 3'd4 && l_strb[i] == 4'b0001 && l_data[i] == 32'h5A) n_wr++;
    n_tests++; if (n_wr != 2) begin n_fail++; $display("FAIL arb_tx_writes: got %0d expected 2", n_wr); end
    rx_ready = 1'b0;
  endtask

  task automatic test_ready_stall();
    logic [2:0]  s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_strb;
    int k;
    arst_n = 1'b0;
    tx_valid = 1'b0; rxr_val = 1'b0;
    stall_left = 20;
    repeat (2) @(negedge clk);
    release_reset();
    k = 0;
    do begin
      @(negedge clk); #2; k++;
    end while (!(avalid === 1'b1 && addr === 3'd2) && k < 100);
    n_tests++;
    if (!(avalid === 1'b1 && addr === 3'd2)) begin
      n_fail++; $display("FAIL stall_timeout: got addr %0d expected 2", addr);
    end
    s_addr = addr; s_data = wdata; s_strb = wstrb;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      n_tests++;
      if (avalid !== 1'b1 || addr !== s_addr || wdata !== s_data || wstrb !== s_strb) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b a=%0d d=%h s=%b expected v=1 a=%0d d=%h s=%b", i,
                 avalid, addr, wdata, wstrb, s_addr, s_data, s_strb);
      end
    end
    test_init("stall_init");
  endtask

  task automatic test_reset_mid_read();
    int k;
    bit seen;
    rxq.delete();
    rxq.push_back(8'h77);
    rxdata_lat = 100000;
    rxr_val = 1'b1;
    clear_log();
    k = 0; seen = 0;
    do begin
      @(negedge clk); #2; k++;
      for (int i = 0; i < l_addr.size(); i++)
        if (l_addr[i] == 3'd4 && l_strb[i] == 4'd0) seen = 1;
    end while (!seen && k < 300);
    n_tests++; if (!seen) begin n_fail++; $display("FAIL mid_timeout: got no RXDATA read expected one"); end
    repeat (2) @(negedge clk);
    n_tests++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL mid_pre_done: got %b expected 1", init_done); end
    #3 arst_n = 1'b0;
    #1;
    n_tests++;
    if (avalid !== 1'b0 || addr !== 3'd0 || wdata !== 32'd0 || wstrb !== 4'd0 ||
        tx_ready !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'd0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outs: got v=%b a=%0d d=%h s=%b txr=%b rxv=%b rxd=%h done=%b expected all 0",
               avalid, addr, wdata, wstrb, tx_ready, rx_valid, rx_data, init_done);
    end
    rxdata_lat = 1; rxr_val = 1'b0; rxq.delete();
    repeat (2) @(negedge clk);
    release_reset();
    k = 0;
    do begin
      @(negedge clk); #2; k++;
    end while (l_addr.size() < 1 && k < 50);
    n_tests++;
    if (l_addr.size() < 1) begin
      n_fail++; $display("FAIL mid_restart_timeout: got 0 accesses expected 1");
    end else if (l_addr[0] !== 3'd0 || l_strb[0] !== 4'b0001 || l_data[0] !== 32'h1) begin
      n_fail++;
      $display("FAIL mid_restart: got a=%0d s=%b d=%h expected a=0 s=0001 d=00000001",
               l_addr[0], l_strb[0], l_data[0]);
    end
  endtask

  initial begin
    test_reset();
    release_reset();
    test_init("init");
    test_tx();
    test_rx_backpressure();
    test_arbitration();
    test_ready_stall();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
